// File: rtl/alu_result_fifo.sv
// Result FIFO behind a 4-bit ALU: buffers {op,y} pairs first-word-fall-through,
// keeps a running sum of accepted results, and supports a flush/drain handshake.
module alu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int ACC_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [3:0]               in_y,
   input  logic [1:0]               in_op,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [3:0]               out_y,
   output logic [1:0]               out_op,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic                     flush_done,
   output logic [ACC_W-1:0]         acc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [5:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           push;
   logic           pop;
   logic           empty;
   logic           full;

   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);
   assign in_ready  = (state == RUN) && !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head is read straight from the array so a fresh entry shows up one cycle after its push.
   assign out_y  = empty ? 4'd0 : mem[rd_ptr][3:0];
   assign out_op = empty ? 2'd0 : mem[rd_ptr][5:4];

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = DRAIN;
         DRAIN:   if (empty) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         acc        <= '0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Pulses on the single cycle that follows DRAIN seeing an empty FIFO.
         flush_done <= (state == DRAIN) && empty;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            acc    <= acc + ACC_W'(in_y);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately left out of reset; occupancy
   // gating on the head makes stale contents invisible and keeps it RAM-mappable.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_op, in_y};
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_COUNT);
   a_drain_blocks : assert property (@(posedge clk) disable iff (!rst_n) (state == DRAIN) |-> !in_ready);

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: a queue-based reference model is
// advanced every cycle and compared against all DUT outputs, plus directed checks.
module tb_alu_result_fifo;

   localparam int DEPTH = 4;
   localparam int ACC_W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [3:0]   in_y;
   logic [1:0]   in_op;
   logic         in_ready;
   logic         out_valid;
   logic [3:0]   out_y;
   logic [1:0]   out_op;
   logic         out_ready;
   logic         flush;
   logic         flush_done;
   logic [7:0]   acc;
   logic [2:0]   count;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_seen  = 0;

   logic [5:0]   sb_q[$];
   int           m_state = 0;   // 0 = RUN, 1 = DRAIN
   logic [7:0]   m_acc   = 8'd0;
   logic         m_fd    = 1'b0;

   alu_result_fifo #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_y       (in_y),
      .in_op      (in_op),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_y      (out_y),
      .out_op     (out_op),
      .out_ready  (out_ready),
      .flush      (flush),
      .flush_done (flush_done),
      .acc        (acc),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model at the edge.
   task automatic cyc(input logic v, input logic [3:0] y, input logic [1:0] op,
                      input logic rdy, input logic fl, input logic rs = 1'b1);
      int   sz;
      logic m_rdy;
      logic m_push;
      logic m_pop;
      logic [5:0] head;
      in_valid  = v;
      in_y      = y;
      in_op     = op;
      out_ready = rdy;
      flush     = fl;
      rst_n     = rs;
      @(negedge clk);
      sz    = sb_q.size();
      m_rdy = (m_state == 0) && (sz < DEPTH);
      head  = (sz != 0) ? sb_q[0] : 6'd0;
      check("in_ready",   32'(in_ready),   32'(m_rdy));
      check("out_valid",  32'(out_valid),  32'(sz != 0));
      check("out_y",      32'(out_y),      32'(head[3:0]));
      check("out_op",     32'(out_op),     32'(head[5:4]));
      check("count",      32'(count),      32'(sz));
      check("acc",        32'(acc),        32'(m_acc));
      check("flush_done", 32'(flush_done), 32'(m_fd));
      m_push = v && m_rdy;
      m_pop  = (sz != 0) && rdy;
      @(posedge clk);
      if (!rs) begin
         sb_q.delete();
         m_state = 0;
         m_acc   = 8'd0;
         m_fd    = 1'b0;
      end else begin
         m_fd = (m_state == 1) && (sz == 0);
         if (m_state == 0 && fl)      m_state = 1;
         else if (m_state == 1 && sz == 0) m_state = 0;
         if (m_pop) void'(sb_q.pop_front());
         if (m_push) begin
            sb_q.push_back({op, y});
            m_acc = m_acc + 8'(y);
         end
      end
      #1;
      if (flush_done) fd_seen++;
   endtask

   task automatic do_reset();
      cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_y      = 4'd0;
      in_op     = 2'd0;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_count",    32'(count),     32'd0);
      check("rst_out_valid",32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready),  32'd1);
      check("rst_acc",      32'(acc),       32'd0);
      cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);

      // Two pushes with consumer stalled
      cyc(1'b1, 4'd3, 2'd0, 1'b0, 1'b0);
      check("fwft_valid", 32'(out_valid), 32'd1);
      check("fwft_y",     32'(out_y),     32'd3);
      cyc(1'b1, 4'd9, 2'd1, 1'b0, 1'b0);
      check("two_count", 32'(count),  32'd2);
      check("two_y",     32'(out_y),  32'd3);
      check("two_op",    32'(out_op), 32'd0);
      check("two_acc",   32'(acc),    32'd12);

      // Fill to full, fifth push refused
      do_reset();
      for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 2'(i), 1'b0, 1'b0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count",    32'(count),    32'd4);
      check("full_acc",      32'(acc),      32'd10);
      cyc(1'b1, 4'd5, 2'd1, 1'b0, 1'b0);
      check("full_hold_count", 32'(count), 32'd4);
      check("full_hold_acc",   32'(acc),   32'd10);
      check("full_hold_head",  32'(out_y), 32'd1);

      // Streaming from full: order preserved across pointer wrap
      for (int i = 0; i < 8; i++) cyc(1'b1, 4'(5 + i), 2'(i), 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
      check("stream_empty", 32'(out_valid), 32'd0);

      // Accumulator wrap
      do_reset();
      for (int i = 0; i < 30; i++) cyc(1'b1, 4'd15, 2'd3, 1'b1, 1'b0);
      check("acc_wrap", 32'(acc), 32'd194);
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);

      // Flush with three entries queued
      do_reset();
      cyc(1'b1, 4'd1, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 4'd2, 2'd1, 1'b0, 1'b0);
      cyc(1'b1, 4'd3, 2'd2, 1'b0, 1'b0);
      fd_seen = 0;
      cyc(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
      check("drain_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 4'd7, 2'd3, 1'b1, 1'b0);
      check("flush_done_pulses", 32'(fd_seen), 32'd1);
      check("post_drain_ready",  32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);

      // Flush while empty, then held high across the return to RUN
      fd_seen = 0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
      check("flush_held_pulses", 32'(fd_seen), 32'd2);

      // Reset during DRAIN
      do_reset();
      for (int i = 1; i <= 3; i++) cyc(1'b1, 4'(i), 2'd1, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
      cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
      check("mid_drain_count", 32'(count), 32'd2);
      fd_seen = 0;
      cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      check("rst_drain_count",    32'(count),      32'd0);
      check("rst_drain_valid",    32'(out_valid),  32'd0);
      check("rst_drain_acc",      32'(acc),        32'd0);
      check("rst_drain_in_ready", 32'(in_ready),   32'd1);
      check("rst_drain_fd",       32'(flush_done), 32'd0);
      cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
      check("rst_drain_no_pulse", 32'(fd_seen), 32'd0);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 99) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of result entries stored; power of two, minimum 2.
REQ-002 SHALL have parameter ACC_W, default 8, meaning running-sum accumulator width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream ALU result is valid.
REQ-006 SHALL have port in_y, input, 4, meaning the ALU result (add/mul/xor/xnor output).
REQ-007 SHALL have port in_op, input, 2, meaning the ALU select {s1,s0} that produced in_y.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts in_y/in_op this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning the FIFO head is valid.
REQ-010 SHALL have port out_y, output, 4, meaning the FIFO head result.
REQ-011 SHALL have port out_op, output, 2, meaning the FIFO head op code.
REQ-012 SHALL have port out_ready, input, 1, meaning the downstream consumer takes the head.
REQ-013 SHALL have port flush, input, 1, meaning a request to stop intake and drain.
REQ-014 SHALL have port flush_done, output, 1, meaning a one-cycle pulse when the drain completes.
REQ-015 SHALL have port acc, output, ACC_W, meaning the running sum of accepted in_y.
REQ-016 SHALL have port count, output, log2(DEPTH)+1, meaning current occupancy.

Function
REQ-017 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready, both evaluated per cycle.
REQ-018 SHALL drive in_ready = (state==RUN) && (count<DEPTH), combinationally from registered state.
REQ-019 SHALL, on push, write {in_op,in_y} at wr_ptr, advance wr_ptr modulo DEPTH, and increment count.
REQ-020 SHALL, on pop, advance rd_ptr modulo DEPTH and decrement count.
REQ-021 SHALL leave count unchanged on simultaneous push and pop while writing and reading the correct entries.
REQ-022 SHALL operate first-word-fall-through: an entry pushed at edge N is visible on out_y/out_op with out_valid=1 after edge N (latency 1 cycle, empty to output).
REQ-023 SHALL drive out_valid = (count!=0), and out_y=0 and out_op=0 whenever count==0.
REQ-024 SHALL hold the head stable while out_valid=1 and out_ready=0.
REQ-025 SHALL wrap pointers from DEPTH-1 to 0 with no loss of data.
REQ-026 SHALL, on push, update acc <= acc + zero-extended in_y, wrapping modulo 2^ACC_W; pop SHALL NOT affect acc.
REQ-027 SHALL implement FSM states RUN and DRAIN.
REQ-028 SHALL transition RUN->DRAIN at the edge where flush=1 is sampled in RUN; a push in that same cycle SHALL still complete.
REQ-029 SHALL, in DRAIN, keep in_ready=0 while pops continue normally.
REQ-030 SHALL transition DRAIN->RUN at the edge where count==0 is sampled (including count reaching 0 via that cycle's pop taking effect next cycle), and assert flush_done=1 for exactly the first cycle back in RUN.
REQ-031 SHALL ignore flush while in DRAIN; flush held high after return to RUN SHALL re-enter DRAIN on the next edge.
REQ-032 SHALL, when flush is asserted with count==0 in RUN, go to DRAIN for one cycle and then return to RUN with flush_done pulse.
REQ-033 SHALL never overflow or underflow: no push when full, no pop when empty.

Reset
REQ-034 SHALL, on rst_n=0 at a rising edge, set state=RUN, wr_ptr=0, rd_ptr=0, count=0, acc=0, flush_done=0, so out_valid=0, out_y=0, out_op=0, in_ready=1 the following cycle.
REQ-035 SHALL give reset priority over push, pop and flush, discarding stored entries and aborting any DRAIN mid-operation; storage array contents need not be reset.

Verification
REQ-036 SHALL verify: reset, then push y=3 op=00, y=9 op=01 with out_ready=0 -> count=2, out_y=3, out_op=00, acc=12.
REQ-037 SHALL verify: push 4 entries (1,2,3,4) with out_ready=0 -> in_ready=0, count=4; a fifth in_valid is not accepted; acc=10.
REQ-038 SHALL verify: full FIFO, out_ready=1 and in_valid=1 continuously for 8 cycles -> output order 1,2,3,4 then new data in order, pointers wrap, no loss.
REQ-039 SHALL verify: push 15 thirty times with ACC_W=8 -> acc = 450 mod 256 = 194.
REQ-040 SHALL verify: count=3, pulse flush, out_ready=1 -> in_ready=0 for the drain, 3 pops, flush_done high exactly one cycle, then in_ready=1.
REQ-041 SHALL verify: rst_n=0 during DRAIN with count=2 -> next cycle count=0, out_valid=0, acc=0, in_ready=1, no flush_done.
